// File: rtl/sblk_pkg.sv
// Shared types for the super-block sequencer: instruction layout, FSM states, field helpers.
package sblk_pkg;

  localparam int unsigned WID_INST_TN = 4;
  localparam int unsigned WID_INST_TM = 9;
  localparam int unsigned WID_INST_TP = 5;
  localparam int unsigned WID_INST_LN = 5;
  localparam int unsigned WID_INST_LP = 5;
  localparam int unsigned WID_INST    = WID_INST_TN + WID_INST_TM + WID_INST_TP +
                                        WID_INST_LN + WID_INST_LP;

  // First member lands at the MSBs, so tn sits at the LSBs of inst_data.
  typedef struct packed {
    logic [WID_INST_LP-1:0] lp;
    logic [WID_INST_LN-1:0] ln;
    logic [WID_INST_TP-1:0] tp;
    logic [WID_INST_TM-1:0] tm;
    logic [WID_INST_TN-1:0] tn;
  } sblk_inst_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCompute,
    StDrain
  } sblk_state_e;

  function automatic logic inst_has_zero(sblk_inst_t inst);
    return (inst.tn == '0) || (inst.tm == '0) || (inst.tp == '0) ||
           (inst.ln == '0) || (inst.lp == '0);
  endfunction

endpackage

// File: rtl/sblk_delay_line.sv
// Fixed-latency shift register; output is the input delayed by exactly DEPTH cycles.
module sblk_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      sr_q[0] <= d_i;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/sblk_controller.sv
// Super-block sequencer: loads activations round-robin into the tile buffers, then walks the
// compute loop nest emitting weight/activation/psum addresses and delayed psum write-back.
module sblk_controller
  import sblk_pkg::*;
#(
  parameter int unsigned N_TILE       = 4,
  parameter int unsigned WID_WADDR    = 10,
  parameter int unsigned WID_ACT      = 16,
  parameter int unsigned WID_ACTADDR  = 6,
  parameter int unsigned WID_PSUMADDR = 9
) (
  input  logic                    clk_l,
  input  logic                    rst_n,
  input  logic [WID_INST-1:0]     inst_data,
  input  logic                    inst_en,
  input  logic                    act_in_vld,
  input  logic [2*WID_ACT-1:0]    act_in,
  output logic                    act_in_req,
  output logic [WID_WADDR-1:0]    w_rd_addr,
  output logic [WID_ACTADDR-2:0]  act_rd_addr_hbit,
  output logic [WID_ACTADDR-2:0]  act_wr_addr_hbit,
  output logic [N_TILE-1:0]       act_wr_en,
  output logic [WID_PSUMADDR-1:0] psum_rd_addr,
  output logic [WID_PSUMADDR-1:0] psum_wr_addr,
  output logic                    psum_wr_en,
  output logic                    status_sblk
);

  localparam int unsigned WID_N_TILE     = (N_TILE > 1) ? $clog2(N_TILE) : 1;
  localparam int unsigned WID_AE         = WID_ACTADDR - 1;
  localparam int unsigned WB_DELAY_CYCLE = N_TILE + 8;
  localparam int unsigned WID_DRAIN      = $clog2(WB_DELAY_CYCLE + 1);
  localparam logic [WID_N_TILE-1:0] TILE_LAST  = WID_N_TILE'(N_TILE - 1);
  localparam logic [WID_DRAIN-1:0]  DRAIN_INIT = WID_DRAIN'(WB_DELAY_CYCLE - 1);
  localparam logic [N_TILE-1:0]     TILE0_OH   = N_TILE'(1);

  sblk_state_e state_q, state_d;
  sblk_inst_t  inst_q, inst_d, inst_in;

  logic [WID_N_TILE-1:0]  tile_q, tile_d;
  logic [WID_AE-1:0]      entry_q, entry_d;
  logic [WID_INST_TN-1:0] ld_tn_q, ld_tn_d;
  logic [WID_INST_TP-1:0] ld_tp_q, ld_tp_d;

  logic [WID_INST_LN-1:0] ln_q, ln_d;
  logic [WID_INST_LP-1:0] lp_q, lp_d;
  logic [WID_INST_TN-1:0] tn_q, tn_d;
  logic [WID_INST_TP-1:0] tp_q, tp_d;
  logic [WID_INST_TM-1:0] tm_q, tm_d;

  logic [WID_WADDR-1:0]    w_base_q, w_base_d, w_tm_base_q, w_tm_base_d, w_addr_q, w_addr_d;
  logic [WID_AE-1:0]       a_base_q, a_base_d, a_addr_q, a_addr_d;
  logic [WID_PSUMADDR-1:0] p_base_q, p_base_d, p_addr_q, p_addr_d;

  logic                 req_q, req_d, status_q, status_d;
  logic [WID_DRAIN-1:0] drain_q, drain_d;

  logic beat, ld_last, ln_wrap, lp_wrap, tn_wrap, tp_wrap, tm_wrap, cmp_last, drain_done;
  logic [WID_PSUMADDR:0] wb_q;
  logic unused_act;

  assign unused_act = ^act_in;
  assign inst_in    = sblk_inst_t'(inst_data);

  assign beat    = (state_q == StLoad) && act_in_vld;
  assign ld_last = beat && (tile_q == TILE_LAST) &&
                   (ld_tn_q == inst_q.tn - WID_INST_TN'(1)) &&
                   (ld_tp_q == inst_q.tp - WID_INST_TP'(1));

  assign ln_wrap    = (ln_q == inst_q.ln - WID_INST_LN'(1));
  assign lp_wrap    = (lp_q == inst_q.lp - WID_INST_LP'(1));
  assign tn_wrap    = (tn_q == inst_q.tn - WID_INST_TN'(1));
  assign tp_wrap    = (tp_q == inst_q.tp - WID_INST_TP'(1));
  assign tm_wrap    = (tm_q == inst_q.tm - WID_INST_TM'(1));
  assign cmp_last   = (state_q == StCompute) && ln_wrap && lp_wrap && tn_wrap && tp_wrap &&
                      tm_wrap;
  assign drain_done = (drain_q == '0);

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (inst_en) state_d = inst_has_zero(inst_in) ? StDrain : StLoad;
      StLoad:    if (ld_last) state_d = StCompute;
      StCompute: if (cmp_last) state_d = StDrain;
      StDrain:   if (drain_done) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    inst_d      = inst_q;
    tile_d      = tile_q;
    entry_d     = entry_q;
    ld_tn_d     = ld_tn_q;
    ld_tp_d     = ld_tp_q;
    ln_d        = ln_q;
    lp_d        = lp_q;
    tn_d        = tn_q;
    tp_d        = tp_q;
    tm_d        = tm_q;
    w_base_d    = w_base_q;
    w_tm_base_d = w_tm_base_q;
    a_base_d    = a_base_q;
    p_base_d    = p_base_q;
    drain_d     = drain_q;
    req_d       = 1'b0;
    status_d    = (state_d != StIdle);

    if ((state_q == StIdle) && inst_en) begin
      inst_d      = inst_in;
      req_d       = !inst_has_zero(inst_in);
      tile_d      = '0;
      entry_d     = '0;
      ld_tn_d     = '0;
      ld_tp_d     = '0;
      ln_d        = '0;
      lp_d        = '0;
      tn_d        = '0;
      tp_d        = '0;
      tm_d        = '0;
      w_base_d    = '0;
      w_tm_base_d = '0;
      a_base_d    = '0;
      p_base_d    = '0;
      drain_d     = '0;
    end

    if (beat) begin
      if (tile_q == TILE_LAST) begin
        tile_d  = '0;
        entry_d = entry_q + WID_AE'(1);
        if (ld_tn_q == inst_q.tn - WID_INST_TN'(1)) begin
          ld_tn_d = '0;
          ld_tp_d = ld_tp_q + WID_INST_TP'(1);
        end else begin
          ld_tn_d = ld_tn_q + WID_INST_TN'(1);
        end
      end else begin
        tile_d = tile_q + WID_N_TILE'(1);
      end
    end

    // Running bases replace the multiplies: each wrap adds one stride or restores a saved base.
    if ((state_q == StCompute) && !cmp_last) begin
      if (!ln_wrap) begin
        ln_d = ln_q + WID_INST_LN'(1);
      end else begin
        ln_d = '0;
        if (!lp_wrap) begin
          lp_d = lp_q + WID_INST_LP'(1);
        end else begin
          lp_d = '0;
          if (!tn_wrap) begin
            tn_d     = tn_q + WID_INST_TN'(1);
            w_base_d = w_base_q + WID_WADDR'(inst_q.ln);
          end else begin
            tn_d     = '0;
            p_base_d = p_base_q + WID_PSUMADDR'(inst_q.lp);
            if (!tp_wrap) begin
              tp_d     = tp_q + WID_INST_TP'(1);
              w_base_d = w_tm_base_q;
              a_base_d = a_base_q + WID_AE'(inst_q.tn);
            end else begin
              tp_d        = '0;
              tm_d        = tm_q + WID_INST_TM'(1);
              w_base_d    = w_base_q + WID_WADDR'(inst_q.ln);
              w_tm_base_d = w_base_q + WID_WADDR'(inst_q.ln);
              a_base_d    = '0;
            end
          end
        end
      end
    end

    if (cmp_last) begin
      drain_d = DRAIN_INIT;
    end else if ((state_q == StDrain) && !drain_done) begin
      drain_d = drain_q - WID_DRAIN'(1);
    end

    w_addr_d = w_base_d + WID_WADDR'(ln_d);
    a_addr_d = a_base_d + WID_AE'(tn_d);
    p_addr_d = p_base_d + WID_PSUMADDR'(lp_d);
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= '0;
      tile_q      <= '0;
      entry_q     <= '0;
      ld_tn_q     <= '0;
      ld_tp_q     <= '0;
      ln_q        <= '0;
      lp_q        <= '0;
      tn_q        <= '0;
      tp_q        <= '0;
      tm_q        <= '0;
      w_base_q    <= '0;
      w_tm_base_q <= '0;
      a_base_q    <= '0;
      p_base_q    <= '0;
      w_addr_q    <= '0;
      a_addr_q    <= '0;
      p_addr_q    <= '0;
      req_q       <= 1'b0;
      status_q    <= 1'b0;
      drain_q     <= '0;
    end else begin
      inst_q      <= inst_d;
      tile_q      <= tile_d;
      entry_q     <= entry_d;
      ld_tn_q     <= ld_tn_d;
      ld_tp_q     <= ld_tp_d;
      ln_q        <= ln_d;
      lp_q        <= lp_d;
      tn_q        <= tn_d;
      tp_q        <= tp_d;
      tm_q        <= tm_d;
      w_base_q    <= w_base_d;
      w_tm_base_q <= w_tm_base_d;
      a_base_q    <= a_base_d;
      p_base_q    <= p_base_d;
      w_addr_q    <= w_addr_d;
      a_addr_q    <= a_addr_d;
      p_addr_q    <= p_addr_d;
      req_q       <= req_d;
      status_q    <= status_d;
      drain_q     <= drain_d;
    end
  end

  sblk_delay_line #(
    .WIDTH(WID_PSUMADDR + 1),
    .DEPTH(WB_DELAY_CYCLE)
  ) u_wb_delay (
    .clk_i (clk_l),
    .rst_ni(rst_n),
    .d_i   ({(state_q == StCompute), p_addr_q}),
    .q_o   (wb_q)
  );

  always_comb begin
    act_wr_en        = beat ? (TILE0_OH << tile_q) : '0;
    act_wr_addr_hbit = beat ? entry_q : '0;
  end

  assign act_in_req       = req_q;
  assign status_sblk      = status_q;
  assign w_rd_addr        = w_addr_q;
  assign act_rd_addr_hbit = a_addr_q;
  assign psum_rd_addr     = p_addr_q;
  assign psum_wr_en       = wb_q[WID_PSUMADDR];
  assign psum_wr_addr     = wb_q[WID_PSUMADDR-1:0];

endmodule

// File: tb/tb_sblk_controller.sv
// Randomized bench for sblk_controller: a loop-nest reference model predicts every output each
// cycle, and a few hand-computed literals pin the model on the canonical instructions.
module tb_sblk_controller;

  localparam int NT = 4;
  localparam int WB = NT + 8;

  logic        clk_l = 1'b0;
  logic        rst_n;
  logic [27:0] inst_data;
  logic        inst_en;
  logic        act_in_vld;
  logic [31:0] act_in;
  logic        act_in_req;
  logic [9:0]  w_rd_addr;
  logic [4:0]  act_rd_addr_hbit;
  logic [4:0]  act_wr_addr_hbit;
  logic [3:0]  act_wr_en;
  logic [8:0]  psum_rd_addr;
  logic [8:0]  psum_wr_addr;
  logic        psum_wr_en;
  logic        status_sblk;

  sblk_controller dut (
    .clk_l           (clk_l),
    .rst_n           (rst_n),
    .inst_data       (inst_data),
    .inst_en         (inst_en),
    .act_in_vld      (act_in_vld),
    .act_in          (act_in),
    .act_in_req      (act_in_req),
    .w_rd_addr       (w_rd_addr),
    .act_rd_addr_hbit(act_rd_addr_hbit),
    .act_wr_addr_hbit(act_wr_addr_hbit),
    .act_wr_en       (act_wr_en),
    .psum_rd_addr    (psum_rd_addr),
    .psum_wr_addr    (psum_wr_addr),
    .psum_wr_en      (psum_wr_en),
    .status_sblk     (status_sblk)
  );

  always #5 clk_l = ~clk_l;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 loading, 2 computing, 3 draining.
  int m_ph = 0, m_req = 0, m_beat = 0, m_nb = 0, m_k = 0, m_total = 0, m_drain = 0;
  int m_tn, m_tm, m_tp, m_ln, m_lp;

  always @(posedge clk_l) begin
    int tn, tm, tp, ln, lp;
    if (!rst_n) begin
      m_ph <= 0; m_req <= 0; m_beat <= 0; m_k <= 0; m_drain <= 0;
    end else begin
      m_req <= 0;
      case (m_ph)
        0: if (inst_en) begin
          tn = int'(inst_data[3:0]);   tm = int'(inst_data[12:4]);
          tp = int'(inst_data[17:13]); ln = int'(inst_data[22:18]);
          lp = int'(inst_data[27:23]);
          m_tn <= tn; m_tm <= tm; m_tp <= tp; m_ln <= ln; m_lp <= lp;
          if (tn * tm * tp * ln * lp == 0) begin
            m_ph <= 3; m_drain <= 0;
          end else begin
            m_ph <= 1; m_req <= 1; m_beat <= 0;
            m_nb <= tn * tp * NT;
            m_total <= tm * tp * tn * lp * ln;
          end
        end
        1: if (act_in_vld) begin
          m_beat <= m_beat + 1;
          if (m_beat + 1 == m_nb) begin m_ph <= 2; m_k <= 0; end
        end
        2: if (m_k == m_total - 1) begin m_ph <= 3; m_drain <= WB - 1; end
           else m_k <= m_k + 1;
        default: if (m_drain == 0) m_ph <= 0; else m_drain <= m_drain - 1;
      endcase
    end
  end

  int hist_v[WB];
  int hist_a[WB];
  int mon_req = 0, mon_beat = 0, mon_wr = 0, mon_busy = 0;
  int cap_w[$];
  int cap_a[$];
  int cap_p[$];

  always @(negedge clk_l) begin
    int r, ln, lp, tn, tp, tm, ew, ea, ep, een;
    if (!rst_n) begin
      for (int i = 0; i < WB; i++) begin hist_v[i] = 0; hist_a[i] = 0; end
    end else begin
      chk("status_sblk", 32'(status_sblk), 32'(m_ph != 0));
      chk("act_in_req", 32'(act_in_req), 32'(m_req));
      een = (m_ph == 1 && act_in_vld) ? (1 << (m_beat % NT)) : 0;
      chk("act_wr_en", 32'(act_wr_en), een);
      chk("act_wr_addr_hbit", 32'(act_wr_addr_hbit), (een != 0) ? (m_beat / NT) % 32 : 0);
      ep = 0;
      if (m_ph == 2) begin
        ln = m_k % m_ln; r = m_k / m_ln;
        lp = r % m_lp;   r = r / m_lp;
        tn = r % m_tn;   r = r / m_tn;
        tp = r % m_tp;   tm = r / m_tp;
        ew = ((tm * m_tn + tn) * m_ln + ln) % 1024;
        ea = (tp * m_tn + tn) % 32;
        ep = ((tm * m_tp + tp) * m_lp + lp) % 512;
        chk("w_rd_addr", 32'(w_rd_addr), ew);
        chk("act_rd_addr_hbit", 32'(act_rd_addr_hbit), ea);
        chk("psum_rd_addr", 32'(psum_rd_addr), ep);
        cap_w.push_back(int'(w_rd_addr));
        cap_a.push_back(int'(act_rd_addr_hbit));
        cap_p.push_back(int'(psum_rd_addr));
      end
      chk("psum_wr_en", 32'(psum_wr_en), hist_v[WB-1]);
      if (hist_v[WB-1] != 0) chk("psum_wr_addr", 32'(psum_wr_addr), hist_a[WB-1]);
      for (int i = WB - 1; i > 0; i--) begin
        hist_v[i] = hist_v[i-1]; hist_a[i] = hist_a[i-1];
      end
      hist_v[0] = (m_ph == 2) ? 1 : 0;
      hist_a[0] = ep;
      if (act_in_req) mon_req++;
      if (act_wr_en != 0) mon_beat++;
      if (psum_wr_en) mon_wr++;
      if (status_sblk) mon_busy++;
    end
  end

  int s_req, s_beat, s_wr, s_busy, s_cap;

  task automatic tick();
    @(posedge clk_l);
    #1;
  endtask

  function automatic logic [27:0] mk(input int tn, input int tm, input int tp, input int ln,
                                     input int lp);
    return {5'(lp), 5'(ln), 5'(tp), 9'(tm), 4'(tn)};
  endfunction

  task automatic run_inst(input logic [27:0] d, input int mode, input bit poke);
    int nb, sent, g;
    s_req = mon_req; s_beat = mon_beat; s_wr = mon_wr; s_busy = mon_busy; s_cap = cap_w.size();
    inst_data = d;
    inst_en = 1'b1;
    tick();
    inst_en = 1'b0;
    nb = int'(d[3:0]) * int'(d[17:13]) * NT;
    if (int'(d[12:4]) * int'(d[22:18]) * int'(d[27:23]) == 0) nb = 0;
    sent = 0;
    g = 0;
    while (sent < nb && g < 10000) begin
      case (mode)
        0:       act_in_vld = 1'b1;
        1:       act_in_vld = (g % 2 == 0);
        default: act_in_vld = 1'(($urandom_range(0, 1)));
      endcase
      act_in = $urandom;
      tick();
      if (act_in_vld) sent++;
      g++;
    end
    act_in_vld = 1'b0;
    g = 0;
    while (status_sblk && g < 5000) begin
      inst_en = poke && (g == 3);
      inst_data = (poke && g == 3) ? 28'($urandom) : d;
      act_in_vld = 1'(($urandom_range(0, 1)));
      tick();
      g++;
    end
    inst_en = 1'b0;
    act_in_vld = 1'b0;
    chk("busy_bound", 32'(status_sblk), 0);
    tick();
  endtask

  int exp_aw[7] = '{0, 1, 2, 0, 1, 2, 3};
  int exp_ap[7] = '{0, 0, 0, 1, 1, 1, 0};

  initial begin
    int mx_a, mx_p;
    rst_n = 1'b0;
    inst_en = 1'b1;
    inst_data = mk(4, 1, 1, 3, 2);
    act_in_vld = 1'b0;
    act_in = '0;
    repeat (2) @(negedge clk_l);
    chk("rst_status", 32'(status_sblk), 0);
    chk("rst_req", 32'(act_in_req), 0);
    chk("rst_act_wr_en", 32'(act_wr_en), 0);
    chk("rst_psum_wr_en", 32'(psum_wr_en), 0);
    chk("rst_w_rd_addr", 32'(w_rd_addr), 0);
    chk("rst_psum_rd_addr", 32'(psum_rd_addr), 0);
    chk("rst_act_rd_addr", 32'(act_rd_addr_hbit), 0);
    chk("rst_psum_wr_addr", 32'(psum_wr_addr), 0);
    @(posedge clk_l);
    #1;
    rst_n = 1'b1;
    inst_en = 1'b0;
    tick();
    tick();

    // Inst A, dense beats
    run_inst(mk(4, 1, 1, 3, 2), 0, 1'b0);
    chk("A_req_pulses", 32'(mon_req - s_req), 1);
    chk("A_beats", 32'(mon_beat - s_beat), 16);
    chk("A_wr_pulses", 32'(mon_wr - s_wr), 24);
    chk("A_busy_cycles", 32'(mon_busy - s_busy), 52);
    chk("A_cmp_cycles", 32'(cap_w.size() - s_cap), 24);
    if (cap_w.size() >= s_cap + 7) begin
      for (int i = 0; i < 7; i++) begin
        chk("A_w_seq", 32'(cap_w[s_cap+i]), exp_aw[i]);
        chk("A_p_seq", 32'(cap_p[s_cap+i]), exp_ap[i]);
      end
    end

    // Inst B
    run_inst(mk(2, 2, 3, 2, 2), 0, 1'b0);
    chk("B_beats", 32'(mon_beat - s_beat), 24);
    chk("B_wr_pulses", 32'(mon_wr - s_wr), 48);
    chk("B_cmp_cycles", 32'(cap_w.size() - s_cap), 48);
    mx_a = 0;
    mx_p = 0;
    for (int i = s_cap; i < cap_w.size(); i++) begin
      if (cap_a[i] > mx_a) mx_a = cap_a[i];
      if (cap_p[i] > mx_p) mx_p = cap_p[i];
    end
    chk("B_psum_max", 32'(mx_p), 11);
    chk("B_act_max", 32'(mx_a), 5);

    // Inst A with every-other-cycle beats and an ignored inst_en while busy
    run_inst(mk(4, 1, 1, 3, 2), 1, 1'b1);
    chk("Agap_req_pulses", 32'(mon_req - s_req), 1);
    chk("Agap_beats", 32'(mon_beat - s_beat), 16);
    chk("Agap_wr_pulses", 32'(mon_wr - s_wr), 24);

    // Zero count field
    run_inst(mk(3, 0, 2, 2, 2), 0, 1'b0);
    chk("Z_busy_cycles", 32'(mon_busy - s_busy), 1);
    chk("Z_req_pulses", 32'(mon_req - s_req), 0);
    chk("Z_beats", 32'(mon_beat - s_beat), 0);
    chk("Z_wr_pulses", 32'(mon_wr - s_wr), 0);

    // Address truncation boundaries
    run_inst(mk(15, 3, 1, 31, 1), 2, 1'b1);
    run_inst(mk(1, 20, 31, 1, 1), 2, 1'b0);
    run_inst(mk(15, 1, 31, 1, 1), 2, 1'b0);

    for (int n = 0; n < 4; n++) begin
      run_inst(mk($urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 3),
                  $urandom_range(1, 4), $urandom_range(1, 4)), 2, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of compute
    inst_data = mk(2, 2, 3, 2, 2);
    inst_en = 1'b1;
    tick();
    inst_en = 1'b0;
    act_in_vld = 1'b1;
    repeat (24) tick();
    act_in_vld = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    chk("midrst_status", 32'(status_sblk), 0);
    chk("midrst_wr_en", 32'(psum_wr_en), 0);
    rst_n = 1'b1;
    s_wr = mon_wr;
    repeat (20) tick();
    chk("post_rst_wr_pulses", 32'(mon_wr - s_wr), 0);
    chk("post_rst_status", 32'(status_sblk), 0);

    run_inst(mk(2, 1, 2, 2, 3), 2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sblk_controller.md
Name: sblk_controller

Overview:
- Sequencer for one super-block (sblk) of the tiled DNN accelerator.
- Accepts a packed loop-count instruction, then requests and distributes activation beats round-robin into N_TILE per-tile activation buffers.
- Then walks the compute loop nest, generating weight, activation and psum read addresses, plus delayed psum write-back addresses and enables.
- Raises status_sblk while an instruction is in flight.

Parameters:
N_TILE, 4, number of PE tiles / activation buffers
WID_N_TILE, $clog2(N_TILE), tile-pointer width
WID_WADDR, 10, weight buffer address width
WID_ACT, 16, activation word width
WID_ACTADDR, 6, activation buffer address width (2 words per entry)
WID_PSUMADDR, 9, psum buffer address width
WID_INST_TN/TM/TP/LN/LP, 4/9/5/5/5, instruction field widths
WID_INST, sum of field widths (28), instruction width
WB_DELAY_CYCLE, N_TILE+8, psum read-to-write latency in cycles

Ports:
clk_l  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
inst_data  in  WID_INST  {n_lp,n_ln,n_tp,n_tm,n_tn}, n_tn at LSBs
inst_en  in  1  one-cycle instruction strobe
act_in_vld  in  1  activation beat valid
act_in  in  2*WID_ACT  two activation words; data routed externally, unused internally
act_in_req  out  1  one-cycle load request pulse
w_rd_addr  out  WID_WADDR  weight read address
act_rd_addr_hbit  out  WID_ACTADDR-1  activation read entry address
act_wr_addr_hbit  out  WID_ACTADDR-1  activation write entry address
act_wr_en  out  N_TILE  one-hot tile write enable
psum_rd_addr  out  WID_PSUMADDR  psum read address
psum_wr_addr  out  WID_PSUMADDR  psum write address
psum_wr_en  out  1  psum write enable
status_sblk  out  1  busy flag

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0.
- Outputs are registered except act_wr_en and act_wr_addr_hbit, which are combinational from act_in_vld and the registered pointers.
- IDLE:
  - inst_en=1 latches all five fields.
  - Next cycle: status_sblk=1, act_in_req pulses high for exactly 1 cycle, FSM enters LOAD.
  - inst_en while not IDLE is ignored.
- Zero count field: if any field is 0, status_sblk is high for 1 cycle, no request and no writes occur, then IDLE.
- LOAD:
  - Expect NB = n_tn*n_tp*N_TILE beats; gaps in act_in_vld are allowed.
  - Each beat with act_in_vld=1: act_wr_en = one-hot(tile_ptr), act_wr_addr_hbit = entry_ptr.
  - tile_ptr increments; on wrap from N_TILE-1 to 0, entry_ptr increments.
  - act_in_vld outside LOAD is ignored and drives act_wr_en=0.
  - After beat NB, go to COMPUTE next cycle.
- COMPUTE: loop nest, outer to inner: tm < n_tm, tp < n_tp, tn < n_tn, lp < n_lp, ln < n_ln.
  - One address set per cycle, no stalls.
  - act_rd_addr_hbit = tp*n_tn + tn.
  - w_rd_addr = (tm*n_tn + tn)*n_ln + ln.
  - psum_rd_addr = (tm*n_tp + tp)*n_lp + lp.
  - Compute addresses with running base registers; no multipliers required.
  - All addresses truncate modulo 2^width.
  - Cycle count = n_tm*n_tp*n_tn*n_lp*n_ln; after the last cycle go to DRAIN.
- Write-back:
  - psum_wr_en and psum_wr_addr are the compute-valid flag and psum_rd_addr delayed exactly WB_DELAY_CYCLE cycles.
  - psum_wr_en is 0 otherwise.
- DRAIN: wait until the last delayed write has been issued, then status_sblk falls and FSM returns to IDLE.
  - A new inst_en is accepted from the cycle status_sblk is 0.
- Reset mid-operation: immediate abort; delay line cleared; no spurious psum_wr_en after reset release.

Decomposition:
- Package sblk_pkg:
  - Instruction field widths.
  - Packed struct sblk_inst_t {lp,ln,tp,tm,tn}.
  - FSM enum {IDLE, LOAD, COMPUTE, DRAIN}.
- Sub-module sblk_delay_line: parameterised WIDTH/DEPTH shift register with async reset, used for {valid, psum addr}.

Test Plan:
- Reset: hold rst_n low 2 cycles -> every output 0, status_sblk=0; inst_en during reset has no effect.
- Inst A {tn=4,tm=1,tp=1,ln=3,lp=2}:
  - One act_in_req pulse; 16 beats.
  - act_wr_en cycles 0001,0010,0100,1000; act_wr_addr_hbit goes 0..3.
  - Then 24 compute cycles: w_rd_addr runs 0,1,2 (tn=0), 3,4,5 (tn=1) ... per lp; psum_rd_addr takes values 0,1.
- Inst A write-back: 24 psum_wr_en pulses, each exactly 12 cycles after its read; status_sblk falls after the final write.
- Inst B after status_sblk falls, {tn=2,tm=2,tp=3,ln=2,lp=2}:
  - 24 beats, act_wr_addr_hbit goes 0..5.
  - 48 compute cycles; psum_rd_addr covers 0..11; act_rd_addr_hbit covers 0..5.
- Gapped act_in_vld (every other cycle) -> identical write sequence; COMPUTE starts only after beat NB.
- inst_en pulsed while busy is ignored; an instruction with tm=0 -> 1-cycle status_sblk, no act_in_req, no writes.
